// File: rtl/turbo_frame_sched.sv
// turbo_frame_sched: collects N serial bits into a frame, launches the turbo
// encoder, captures its parallel NY x L output and streams it out bit-serially
// in column-major order. One frame in flight, WAIT timeout guard, frame counter.
//
// state | meaning
// FILL  | accepting serial input bits into xbuf
// START | one-cycle encoder launch pulse
// WAIT  | waiting for encoder out_valid, bounded by TIMEOUT
// DRAIN | streaming ybuf out under valid/ready
module turbo_frame_sched #(
    parameter int N         = 10,
    parameter int NOUT      = 2,
    parameter int TAIL_BITS = 2,
    parameter int TIMEOUT   = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  s_valid,
    input  logic                                  s_bit,
    output logic                                  s_ready,
    output logic                                  enc_in_valid,
    output logic [N-1:0]                          enc_x,
    input  logic                                  enc_out_valid,
    input  logic [2*NOUT:0][N+TAIL_BITS-1:0]      enc_y,
    output logic                                  m_valid,
    output logic                                  m_bit,
    output logic                                  m_last,
    input  logic                                  m_ready,
    output logic                                  busy,
    output logic [15:0]                           frame_count,
    output logic                                  timeout_err
);

    localparam int NY = 1 + 2*NOUT;
    localparam int L  = N + TAIL_BITS;
    localparam int IW = $clog2(N + 1);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam int KW = (L > 1) ? $clog2(L) : 1;
    localparam int RW = (NY > 1) ? $clog2(NY) : 1;

    localparam logic [IW-1:0] IN_LAST   = IW'(N - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
    localparam logic [KW-1:0] K_LAST    = KW'(L - 1);
    localparam logic [RW-1:0] R_LAST    = RW'(NY - 1);

    typedef enum logic [1:0] {FILL, START, WAIT, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [N-1:0]            xbuf;
    logic [NY-1:0][L-1:0]    ybuf;
    logic [IW-1:0]           in_cnt;
    logic [WW-1:0]           wait_cnt;
    logic [KW-1:0]           k;
    logic [RW-1:0]           r;
    logic                    at_last;

    // Outputs decode purely from registered state so nothing depends
    // combinationally on s_valid or m_ready.
    assign at_last      = (r == R_LAST) && (k == K_LAST);
    assign s_ready      = (state_q == FILL);
    assign enc_in_valid = (state_q == START);
    assign busy         = (state_q != FILL);
    assign m_valid      = (state_q == DRAIN);
    assign m_last       = m_valid && at_last;
    assign m_bit        = m_valid && ybuf[r][k];
    assign enc_x        = xbuf;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= FILL;
        else     state_q <= state_d;
    end

    // Next-state decode; a capture on the timeout cycle takes priority.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FILL:    if (s_valid && (in_cnt == IN_LAST)) state_d = START;
            START:   state_d = WAIT;
            WAIT:    if (enc_out_valid)             state_d = DRAIN;
                     else if (wait_cnt == WAIT_LAST) state_d = FILL;
            DRAIN:   if (m_ready && at_last)         state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // Buffers, counters and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            xbuf        <= '0;
            ybuf        <= '0;
            in_cnt      <= '0;
            wait_cnt    <= '0;
            k           <= '0;
            r           <= '0;
            frame_count <= '0;
            timeout_err <= 1'b0;
        end else begin
            unique case (state_q)
                FILL: begin
                    if (s_valid) begin
                        xbuf[in_cnt] <= s_bit;
                        in_cnt       <= (in_cnt == IN_LAST) ? '0 : in_cnt + IW'(1);
                    end
                end
                START: begin
                    wait_cnt <= '0;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + WW'(1);
                    if (enc_out_valid) begin
                        ybuf <= enc_y;
                        r    <= '0;
                        k    <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        timeout_err <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (m_ready) begin
                        if (r == R_LAST) begin
                            r <= '0;
                            if (k == K_LAST) begin
                                k           <= '0;
                                frame_count <= frame_count + 16'd1;
                            end else begin
                                k <= k + KW'(1);
                            end
                        end else begin
                            r <= r + RW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_turbo_frame_sched.sv
// Directed bench for turbo_frame_sched with a behavioural encoder stub that
// answers a programmable number of cycles after enc_in_valid.
module tb_turbo_frame_sched;

    localparam int N     = 10;
    localparam int NY    = 5;
    localparam int L     = 12;
    localparam int NBITS = NY * L;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 s_valid, s_bit, s_ready;
    logic                 enc_in_valid;
    logic [N-1:0]         enc_x;
    logic                 enc_out_valid;
    logic [NY-1:0][L-1:0] enc_y;
    logic                 m_valid, m_bit, m_last, m_ready;
    logic                 busy;
    logic [15:0]          frame_count;
    logic                 timeout_err;

    int   errors = 0;
    int   checks = 0;

    int   stub_delay;
    logic stub_en;
    int   stub_cnt = 0;
    logic stub_ov  = 1'b0;
    logic force_ov;

    turbo_frame_sched #(.N(N), .NOUT(2), .TAIL_BITS(2), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_bit(s_bit), .s_ready(s_ready),
        .enc_in_valid(enc_in_valid), .enc_x(enc_x),
        .enc_out_valid(enc_out_valid), .enc_y(enc_y),
        .m_valid(m_valid), .m_bit(m_bit), .m_last(m_last), .m_ready(m_ready),
        .busy(busy), .frame_count(frame_count), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    assign enc_out_valid = stub_ov | force_ov;

    // Encoder stub: out_valid pulses stub_delay cycles after the start pulse.
    always @(negedge clk) begin
        if (enc_in_valid && stub_en) begin
            stub_cnt <= stub_delay;
            stub_ov  <= 1'b0;
        end else if (stub_cnt > 1) begin
            stub_cnt <= stub_cnt - 1;
            stub_ov  <= 1'b0;
        end else if (stub_cnt == 1) begin
            stub_cnt <= 0;
            stub_ov  <= 1'b1;
        end else begin
            stub_ov <= 1'b0;
        end
    end

    function automatic logic exp_bit(input int sel, input int rr, input int kk);
        if (sel == 0) return ((rr + kk) % 2) != 0;
        return ((rr*3 + kk*5 + rr*kk) % 7) > 3;
    endfunction

    task automatic set_y(input int sel);
        for (int rr = 0; rr < NY; rr++)
            for (int kk = 0; kk < L; kk++)
                enc_y[rr][kk] = exp_bit(sel, rr, kk);
    endtask

    task automatic reset_dut(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Feeds cnt bits of 'bits' (bit 0 first); returns at the sample after the last accept.
    task automatic send_frame(input logic [N-1:0] bits, input int cnt);
        int i, cyc;
        i = 0; cyc = 0;
        while (i < cnt && cyc < 500) begin
            s_valid = 1'b1;
            s_bit   = bits[i];
            if (s_ready) i++;
            @(posedge clk); #1;
            cyc++;
        end
        s_valid = 1'b0;
        s_bit   = 1'b0;
        if (i < cnt) begin
            checks++; errors++;
            $display("FAIL send_timeout accepted=%0d required=%0d", i, cnt);
        end
    endtask

    // Consumes 'stop' output bits, checking order, m_last, hold stability and stall.
    task automatic drain_frame(input int sel, input bit bp, input int stop);
        int   idx, cyc;
        bit   held;
        logic hb, hl, eb, el;
        idx = 0; cyc = 0; held = 0; hb = 0; hl = 0;
        while (idx < stop && cyc < 3000) begin
            if (m_valid) begin
                if (held) begin
                    checks++;
                    if (m_bit !== hb || m_last !== hl) begin
                        errors++;
                        $display("FAIL hold_stable idx=%0d got=%b/%b exp=%b/%b", idx, m_bit, m_last, hb, hl);
                    end
                end
                checks++;
                if (s_ready !== 1'b0 || enc_in_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL drain_stall s_ready=%b enc_in_valid=%b exp=0/0", s_ready, enc_in_valid);
                end
                m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                if (m_ready) begin
                    eb = exp_bit(sel, idx % NY, idx / NY);
                    el = (idx == NBITS - 1);
                    checks++;
                    if (m_bit !== eb || m_last !== el) begin
                        errors++;
                        $display("FAIL drain_bit idx=%0d got=%b/%b exp=%b/%b", idx, m_bit, m_last, eb, el);
                    end
                    idx++;
                    held = 0;
                end else begin
                    hb = m_bit; hl = m_last; held = 1;
                end
            end else begin
                m_ready = 1'b0;
                if (idx > 0) begin
                    checks++; errors++;
                    $display("FAIL drain_gap idx=%0d m_valid=%b exp=1", idx, m_valid);
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        m_ready = 1'b0;
        if (idx < stop) begin
            checks++; errors++;
            $display("FAIL drain_timeout got=%0d bits exp=%0d", idx, stop);
        end
    endtask

    task automatic check_done(input logic [15:0] fc);
        checks++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0 || frame_count !== fc) begin
            errors++;
            $display("FAIL frame_done s_ready=%b m_valid=%b fc=%0d exp=1/0/%0d", s_ready, m_valid, frame_count, fc);
        end
    endtask

    task automatic test_reset();
        int pulses;
        reset_dut(2);
        checks++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0 || busy !== 1'b0 || m_bit !== 1'b0 || m_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl s_ready=%b m_valid=%b busy=%b m_bit=%b m_last=%b exp=1/0/0/0/0",
                     s_ready, m_valid, busy, m_bit, m_last);
        end
        checks++;
        if (frame_count !== 16'd0 || timeout_err !== 1'b0 || enc_x !== '0 || enc_in_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_status fc=%0d terr=%b enc_x=%b eiv=%b exp=0/0/0/0",
                     frame_count, timeout_err, enc_x, enc_in_valid);
        end
        pulses = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (enc_in_valid) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL idle_pulses got=%0d exp=0", pulses);
        end
    endtask

    task automatic test_fill_start();
        logic [N-1:0] f;
        f = 10'b0111000111;
        stub_delay = 1; set_y(0);
        send_frame(f, N);
        checks++;
        if (enc_in_valid !== 1'b1 || busy !== 1'b1 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL start_cycle eiv=%b busy=%b s_ready=%b exp=1/1/0", enc_in_valid, busy, s_ready);
        end
        checks++;
        if (enc_x !== f) begin errors++; $display("FAIL start_enc_x got=%b exp=%b", enc_x, f); end
        @(posedge clk); #1;
        checks++;
        if (enc_in_valid !== 1'b0 || m_valid !== 1'b0 || busy !== 1'b1 || enc_x !== f) begin
            errors++;
            $display("FAIL wait_cycle eiv=%b m_valid=%b busy=%b enc_x=%b exp=0/0/1/%b", enc_in_valid, m_valid, busy, enc_x, f);
        end
        @(posedge clk); #1;
        checks++;
        if (m_valid !== 1'b1) begin errors++; $display("FAIL drain_entry m_valid=%b exp=1", m_valid); end
        drain_frame(0, 0, NBITS);
        check_done(16'd1);
    endtask

    task automatic test_drain_order();
        stub_delay = 3; set_y(0);
        send_frame(10'b1100101011, N);
        checks++;
        if (enc_x !== 10'b1100101011) begin errors++; $display("FAIL order_enc_x got=%b exp=%b", enc_x, 10'b1100101011); end
        drain_frame(0, 0, NBITS);
        check_done(16'd2);
    endtask

    task automatic test_backpressure();
        stub_delay = 2; set_y(1);
        send_frame(10'b0110011101, N);
        s_valid = 1'b1; s_bit = 1'b1;
        drain_frame(1, 1, NBITS);
        s_valid = 1'b0; s_bit = 1'b0;
        check_done(16'd3);
        send_frame(10'b1010110010, N);
        checks++;
        if (enc_x !== 10'b1010110010) begin errors++; $display("FAIL held_source_enc_x got=%b exp=%b", enc_x, 10'b1010110010); end
        drain_frame(1, 0, NBITS);
        check_done(16'd4);
    endtask

    task automatic test_back_to_back();
        int cyc, acc, nlast, nvalid;
        int first_acc[2];
        int last_cyc[2];
        stub_delay = 1; set_y(0);
        cyc = 0; acc = 0; nlast = 0; nvalid = 0;
        first_acc[0] = -1; first_acc[1] = -1; last_cyc[0] = -1; last_cyc[1] = -1;
        m_ready = 1'b1;
        while (nlast < 2 && cyc < 400) begin
            s_valid = 1'b1;
            s_bit   = ((acc % N) % 3) == 0;
            if (s_ready) begin
                if (acc % N == 0 && acc / N < 2) first_acc[acc / N] = cyc;
                acc++;
            end
            if (enc_in_valid) begin
                checks++;
                if (enc_x !== 10'b1001001001) begin errors++; $display("FAIL b2b_enc_x got=%b exp=%b", enc_x, 10'b1001001001); end
            end
            if (m_valid) nvalid++;
            if (m_valid && m_last) begin last_cyc[nlast] = cyc; nlast++; end
            if (nlast == 2) s_valid = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        s_valid = 1'b0; m_ready = 1'b0;
        checks++;
        if (first_acc[1] - first_acc[0] != 72) begin
            errors++; $display("FAIL frame_period got=%0d exp=72", first_acc[1] - first_acc[0]);
        end
        checks++;
        if (last_cyc[0] - first_acc[0] != 71) begin
            errors++; $display("FAIL last_latency got=%0d exp=71", last_cyc[0] - first_acc[0]);
        end
        checks++;
        if (nvalid != 2 * NBITS) begin errors++; $display("FAIL b2b_valid_cycles got=%0d exp=%0d", nvalid, 2 * NBITS); end
        check_done(16'd6);
    endtask

    task automatic test_timeout();
        int seen_valid;
        stub_en = 1'b0;
        send_frame(10'b0001110001, N);
        seen_valid = 0;
        for (int j = 1; j <= 16; j++) begin
            @(posedge clk); #1;
            if (m_valid) seen_valid++;
            checks++;
            if (timeout_err !== 1'b0 || busy !== 1'b1) begin
                errors++; $display("FAIL wait_window j=%0d terr=%b busy=%b exp=0/1", j, timeout_err, busy);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (timeout_err !== 1'b1 || s_ready !== 1'b1 || busy !== 1'b0 || frame_count !== 16'd6 || seen_valid != 0) begin
            errors++;
            $display("FAIL timeout_exit terr=%b s_ready=%b busy=%b fc=%0d mvalid_cycles=%0d exp=1/1/0/6/0",
                     timeout_err, s_ready, busy, frame_count, seen_valid);
        end
        stub_en = 1'b1; stub_delay = 1; set_y(1);
        send_frame(10'b1110001110, N);
        drain_frame(1, 0, NBITS);
        check_done(16'd7);
        checks++;
        if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_sticky got=%b exp=1", timeout_err); end
    endtask

    task automatic test_reset_mid_drain();
        stub_delay = 1; set_y(0);
        send_frame(10'b0101010101, N);
        drain_frame(0, 0, 20);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0 || frame_count !== 16'd0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL mid_drain_reset m_valid=%b s_ready=%b busy=%b fc=%0d terr=%b exp=0/1/0/0/0",
                     m_valid, s_ready, busy, frame_count, timeout_err);
        end
        set_y(1);
        force_ov = 1'b1;
        @(posedge clk); #1;
        force_ov = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b1) begin
            errors++; $display("FAIL stray_out_valid m_valid=%b busy=%b s_ready=%b exp=0/0/1", m_valid, busy, s_ready);
        end
        send_frame(10'b1111111111, 4);
        reset_dut(1);
        set_y(0);
        send_frame(10'b0000100001, N);
        checks++;
        if (enc_x !== 10'b0000100001) begin errors++; $display("FAIL refill_enc_x got=%b exp=%b", enc_x, 10'b0000100001); end
        drain_frame(0, 0, NBITS);
        check_done(16'd1);
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_bit = 1'b0; m_ready = 1'b0;
        force_ov = 1'b0; stub_en = 1'b1; stub_delay = 1; enc_y = '0;
        test_reset();
        test_fill_start();
        test_drain_order();
        test_backpressure();
        test_back_to_back();
        test_timeout();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/turbo_frame_sched.md
# turbo_frame_sched

Frame scheduler that sits between a serial bit source and `turbo_encode_behav`. It assembles N serial input bits into a frame and fires the encoder with a one-cycle `in_valid`. It then captures the encoder's parallel `y` output on `out_valid` and streams it out bit-serially under a valid/ready handshake. It owns all sequencing of the encoder: one frame in flight, a timeout guard, and a frame counter.

## Interface
- `N`, 10, information bits per frame (≥2)
- `NOUT`, 2, parity outputs per constituent encoder; output rows NY = 1 + 2*NOUT
- `TAIL_BITS`, 2, tail length; output columns L = N + TAIL_BITS
- `TIMEOUT`, 16, max cycles in WAIT before abandoning the frame (≥2)

Ports:
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `s_valid`  in  1  input bit valid
- `s_bit`  in  1  input data bit
- `s_ready`  out  1  scheduler accepts a bit this cycle
- `enc_in_valid`  out  1  one-cycle start pulse to encoder `in_valid`
- `enc_x`  out  logic [N]  frame to encoder `x`; `enc_x[0]` = first accepted bit
- `enc_out_valid`  in  1  encoder `out_valid`
- `enc_y`  in  logic [NY][L]  encoder `y`
- `m_valid`  out  1  output bit valid
- `m_bit`  out  1  output data bit
- `m_last`  out  1  marks final bit of frame (with `m_valid`)
- `m_ready`  in  1  downstream accepts output bit
- `busy`  out  1  high in any state other than FILL
- `frame_count`  out  16  completed (fully drained) frames, wraps 0xFFFF→0
- `timeout_err`  out  1  sticky; set on WAIT timeout

## Operation
- FSM states: FILL, START, WAIT, DRAIN.
- FILL:
  - `s_ready`=1.
  - Each `s_valid&&s_ready` writes `s_bit` to `xbuf[in_cnt]` and increments `in_cnt`.
  - On the N-th accept, go to START with `in_cnt`←0.
- START:
  - Exactly one cycle: `enc_in_valid`=1, then go to WAIT with `wait_cnt`←0.
  - `enc_x` is driven from `xbuf` continuously; it is stable from START through the end of WAIT.
- WAIT:
  - `wait_cnt` increments each cycle.
  - If `enc_out_valid`=1, latch `enc_y` into `ybuf`, reset `r`=0 and `k`=0, and go to DRAIN.
  - Otherwise, when `wait_cnt`==TIMEOUT-1, set `timeout_err`, discard the frame, and go to FILL.
  - If `enc_out_valid` arrives on the timeout cycle, capture wins.
- DRAIN:
  - `m_valid`=1, `m_bit`=`ybuf[r][k]`.
  - Order is column-major: for k=0..L-1, r=0..NY-1 (systematic, then parity rows per time step). Total NY*L bits.
  - Index advances only on `m_valid&&m_ready`: r++, and when r==NY-1, r←0, k++.
  - `m_last`=1 when r==NY-1 and k==L-1.
  - On the last handshake: `frame_count`++ and go to FILL.
- `enc_out_valid` outside WAIT is ignored; `ybuf` is unchanged.
- `s_valid` outside FILL is not accepted (`s_ready`=0); the source must hold.
- The data path is bit-level only; no arithmetic beyond counters. `in_cnt` is sized to hold N, `wait_cnt` to hold TIMEOUT, `k` to hold L-1, `r` to hold NY-1.

## Timing
- Reset values:
  - state=FILL, `s_ready`=1, `enc_in_valid`=0, `enc_x`=all 0
  - `m_valid`=0, `m_bit`=0, `m_last`=0
  - `busy`=0, `frame_count`=0, `timeout_err`=0
  - all counters 0, `xbuf`/`ybuf` cleared
- Reset mid-frame (any state) aborts immediately; partially filled or undrained data is lost and `frame_count` is not incremented.
- The N-th accept at edge t puts START in cycle t+1 (`enc_in_valid` high for that cycle only) and WAIT from t+2.
- With a 1-cycle encoder, `enc_out_valid` is seen in the first WAIT cycle and DRAIN starts the next cycle.
- Minimum frame period with `m_ready` stuck at 1: N + 1 + 1 + NY*L cycles. For defaults: 10 + 1 + 1 + 60 = 72.
- Output stream:
  - `m_valid` stays high throughout DRAIN regardless of `m_ready`.
  - `m_bit` and `m_last` are held stable while `m_ready`=0.
  - No bubbles between bits while `m_ready`=1.
- After the last output handshake, `s_ready` is 1 in the very next cycle.
- All outputs are registered or decoded from registered state; there is no combinational path from `m_ready` or `s_valid` to any output.

## Test plan
- Reset/idle: assert `rst` 2 cycles → `s_ready`=1, `m_valid`=0, `busy`=0, `frame_count`=0, `timeout_err`=0; no `enc_in_valid` for 20 idle cycles.
- Fill and start: feed 1,1,1,0,0,0,1,1,1,0 back-to-back with the real `turbo_encode_behav` (P=3 interleaver) → a single `enc_in_valid` pulse one cycle after the 10th accept, `enc_x`=that sequence; `busy` rises with START.
- Drain order: replace the encoder with a stub returning `y[r][k]` = (r+k)%2 with `out_valid` 3 cycles after `in_valid` → 60 output bits match column-major order; `m_last` only on bit 60; `frame_count`=1.
- Backpressure: toggle `m_ready` randomly 50% during drain → identical 60-bit sequence; `m_bit` and `m_last` stable while `m_ready`=0; the source is stalled (`s_ready`=0) until drain completes.
- Timeout: stub never asserts `out_valid` → after TIMEOUT=16 WAIT cycles `timeout_err`=1, return to FILL, no `m_valid`, `frame_count` unchanged; the next frame with a good encoder completes and `timeout_err` stays 1.
- Reset mid-drain: assert `rst` after 20 output bits → next cycle `m_valid`=0, state FILL, `frame_count`=0; a stray `enc_out_valid` in FILL is ignored.
